seg_scan_decoder: RTL and testbench

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

---
 rtl/seg_scan_decoder.sv | 229 ++++++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Recovers a 4-digit hex value from a multiplexed, active-low 7-segment
//   display.
//
//   Operation:
//     - The segment and anode lines are sampled through 2-flop synchronizers.
//     - A digit is accepted once its {an_L, seg_L} sample has been stable for
//       STABLE_CYCLES cycles.
//     - A frame is assembled once every position has been seen.
//
// Ports
//   clk      : single clock, all state on the rising edge
//   rst_n    : asynchronous active-low reset
//   seg_L    : active-low segments, seg_L[6]=a .. seg_L[0]=g (asynchronous)
//   an_L     : active-low digit enables, an_L[k] low selects position k
//              (asynchronous)
//   value    : last completed frame, nibble k = digit at position k
//   valid    : one-cycle pulse when value is updated
//   err      : frame contained an undecodable digit; updated with valid
//   timeout  : one-cycle pulse when a partial frame is abandoned
//
// Handshake: valid and timeout are single-cycle, mutually exclusive
// strobes with no backpressure.
//   - value and err are stable from the cycle valid is high until the next
//     valid.
//   - A consumer samples them on the valid cycle.
module seg_scan_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_L,
  input  logic [3:0]  an_L,
  output logic [15:0] value,
  output logic        valid,
  output logic        err,
  output logic        timeout
);

  localparam logic ST_IDLE    = 1'b0;
  localparam logic ST_COLLECT = 1'b1;

  localparam logic [7:0]  STABLE_M1  = 8'(STABLE_CYCLES - 1);
  localparam logic [19:0] TIMEOUT_M1 = 20'(TIMEOUT_CYCLES - 1);

  // Synchronizers reset to all ones.
  // An all-ones an_L is an illegal sample, so nothing coming out of reset
  // can count toward an accept.
  logic [6:0]  seg_s1_q, seg_s2_q;
  logic [3:0]  an_s1_q, an_s2_q;

  logic [10:0] prev_q;
  logic [7:0]  cnt_q, cnt_d;
  logic        state_q, state_d;
  logic [3:0]  seen_q, seen_d;
  logic [15:0] shadow_q, shadow_d;
  logic        ferr_q, ferr_d;
  logic [19:0] tmo_q, tmo_d;
  logic [15:0] value_q, value_d;
  logic        err_q, err_d;
  logic        valid_q, valid_d;
  logic        timeout_q, timeout_d;

  logic [10:0] sample;
  logic        legal;
  logic [1:0]  pos;
  logic [3:0]  pos_bit;
  logic        same;
  logic        accept;
  logic [4:0]  dec;

  // Returns {undecodable, nibble}; unknown patterns decode as nibble 0.
  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h01:   r = 5'h00;
      7'h4F:   r = 5'h01;
      7'h12:   r = 5'h02;
      7'h06:   r = 5'h03;
      7'h4C:   r = 5'h04;
      7'h24:   r = 5'h05;
      7'h20:   r = 5'h06;
      7'h0F:   r = 5'h07;
      7'h00:   r = 5'h08;
      7'h04:   r = 5'h09;
      7'h08:   r = 5'h0A;
      7'h60:   r = 5'h0B;
      7'h31:   r = 5'h0C;
      7'h42:   r = 5'h0D;
      7'h30:   r = 5'h0E;
      7'h38:   r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q <= '1;
      seg_s2_q <= '1;
      an_s1_q  <= '1;
      an_s2_q  <= '1;
    end else begin
      seg_s1_q <= seg_L;
      seg_s2_q <= seg_s1_q;
      an_s1_q  <= an_L;
      an_s2_q  <= an_s1_q;
    end
  end

  assign sample = {an_s2_q, seg_s2_q};

  // Exactly one anode low is a legal sample; this also yields its position.
  always_comb begin
    legal = 1'b1;
    pos   = 2'd0;
    case (an_s2_q)
      4'b1110: pos = 2'd0;
      4'b1101: pos = 2'd1;
      4'b1011: pos = 2'd2;
      4'b0111: pos = 2'd3;
      default: legal = 1'b0;
    endcase
  end

  assign pos_bit = 4'b0001 << pos;
  assign same    = (sample == prev_q);
  assign dec     = decode(seg_s2_q);

  // The count only equals STABLE_CYCLES-1 once per stable run, and it is
  // saturating.
  // So testing the pre-increment value yields a single accept per run.
  assign accept = legal && same && (cnt_q == STABLE_M1);

  always_comb begin
    cnt_d = cnt_q;
    if (!legal) begin
      cnt_d = 8'd0;
    end else if (!same) begin
      cnt_d = 8'd1;
    end else if (cnt_q != 8'hFF) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Frame assembly.
  // Priority order is: completion, then accept, then timeout.
  //   - Completion first keeps valid and timeout exclusive.
  //   - Accept before timeout lets a late digit rescue the frame.
  always_comb begin
    state_d   = state_q;
    seen_d    = seen_q;
    shadow_d  = shadow_q;
    ferr_d    = ferr_q;
    tmo_d     = tmo_q;
    value_d   = value_q;
    err_d     = err_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    if (seen_q == 4'hF) begin
      value_d = shadow_q;
      err_d   = ferr_q;
      valid_d = 1'b1;
      seen_d  = 4'h0;
      ferr_d  = 1'b0;
      tmo_d   = 20'd0;
      state_d = ST_IDLE;
    end else if (accept) begin
      tmo_d   = 20'd0;
      state_d = ST_COLLECT;
      for (int k = 0; k < 4; k++) begin
        if (pos == 2'(k)) shadow_d[k*4 +: 4] = dec[3:0];
      end
      if ((seen_q & pos_bit) != 4'h0) begin
        // Duplicate position: the current digit starts a fresh frame.
        seen_d = pos_bit;
        ferr_d = dec[4];
      end else begin
        seen_d = seen_q | pos_bit;
        ferr_d = ferr_q | dec[4];
      end
    end else if (state_q == ST_COLLECT) begin
      if (tmo_q == TIMEOUT_M1) begin
        timeout_d = 1'b1;
        seen_d    = 4'h0;
        ferr_d    = 1'b0;
        tmo_d     = 20'd0;
        state_d   = ST_IDLE;
      end else begin
        tmo_d = tmo_q + 20'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q    <= '1;
      cnt_q     <= 8'd0;
      state_q   <= ST_IDLE;
      seen_q    <= 4'h0;
      shadow_q  <= 16'h0;
      ferr_q    <= 1'b0;
      tmo_q     <= 20'd0;
      value_q   <= 16'h0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      prev_q    <= sample;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      seen_q    <= seen_d;
      shadow_q  <= shadow_d;
      ferr_q    <= ferr_d;
      tmo_q     <= tmo_d;
      value_q   <= value_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign value   = value_q;
  assign valid   = valid_q;
  assign err     = err_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Testbench for seg_scan_decoder.
//
// Each display step (pins held for n cycles) is fed to a reference model.
//   - The model works on whole steps: run lengths, a seen array and
//     cycle-stamped accept times.
//   - It predicts completed frames (queued) and abandoned frames (counted).
//
// A monitor compares every valid pulse against the queue.
module tb_seg_scan_decoder;

  localparam int S = 4;
  localparam int T = 16;

  // clock / reset
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg_L = 7'h7F;
  logic [3:0]  an_L = 4'hF;
  logic [15:0] value;
  logic        valid, err, timeout;

  always #5 clk = ~clk;

  seg_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .seg_L(seg_L), .an_L(an_L),
    .value(value), .valid(valid), .err(err), .timeout(timeout)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  int total = 0;
  int bad = 0;
  logic [16:0] exp_q[$];
  int n_valid = 0;
  int n_tmo = 0;
  int exp_tmo = 0;
  int last_valid_cyc = 0;
  int step_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model
  logic [6:0]  seg_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
  logic [10:0] m_prev = '1;
  int          m_run = 0;
  bit          m_seen [4];
  logic [3:0]  m_nib [4];
  bit          m_ferr = 1'b0;
  int          m_last_acc = 0;

  function automatic int m_count_seen();
    int c = 0;
    for (int i = 0; i < 4; i++) if (m_seen[i]) c++;
    return c;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < 4; i++) m_seen[i] = 1'b0;
    m_ferr = 1'b0;
  endfunction

  function automatic void m_accept(input int p, input logic [6:0] s);
    bit found = 1'b0;
    logic [3:0] nib = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (seg_tab[i] == s) begin
        found = 1'b1;
        nib = 4'(i);
      end
    end
    if (m_seen[p]) m_clear();
    m_seen[p] = 1'b1;
    m_nib[p] = nib;
    m_ferr = m_ferr | !found;
    if (m_count_seen() == 4) begin
      exp_q.push_back({m_ferr, m_nib[3], m_nib[2], m_nib[1], m_nib[0]});
      m_clear();
    end
  endfunction

  function automatic void m_reset();
    m_clear();
    m_prev = '1;
    m_run = 0;
  endfunction

  // driver: hold {an, seg} on the pins for n cycles and update the model
  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
    logic [10:0] smp;
    int prev_run, p, acc_t;
    bit legal;
    @(negedge clk);
    step_cyc = cyc;
    an_L = an;
    seg_L = seg;
    smp = {an, seg};
    prev_run = (smp == m_prev) ? m_run : 0;
    m_run = prev_run + n;
    m_prev = smp;
    legal = ($countones(~an) == 1);
    p = 0;
    for (int i = 0; i < 4; i++) if (!an[i]) p = i;
    if (legal && prev_run < S && m_run >= S) begin
      acc_t = step_cyc + S - prev_run;
      if (m_count_seen() != 0 && acc_t >= m_last_acc + T + 1) begin
        exp_tmo++;
        m_clear();
      end
      m_accept(p, seg);
      m_last_acc = acc_t;
    end else if (m_count_seen() != 0 && m_last_acc + T + 1 < step_cyc + n) begin
      exp_tmo++;
      m_clear();
    end
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic idle(input int n);
    drive(4'b1111, 7'h7F, n);
  endtask

  task automatic frame(input logic [6:0] s0, s1, s2, s3, input int n);
    drive(4'b1110, s0, n);
    drive(4'b1101, s1, n);
    drive(4'b1011, s2, n);
    drive(4'b0111, s3, n);
  endtask

  // monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid || timeout) check("valid_timeout_excl", {31'b0, valid & timeout}, 0);
      if (valid) begin
        n_valid++;
        last_valid_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_valid", {31'b0, valid}, 0);
        end else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          check("frame_value", {16'b0, value}, {16'b0, e[15:0]});
          check("frame_err", {31'b0, err}, {31'b0, e[16]});
        end
      end
      if (timeout) n_tmo++;
    end
  end

  // stimulus
  initial begin
    int base_v, base_t;
    logic [3:0] an;
    logic [6:0] seg;
    int p, n, kind;

    // reset state
    m_reset();
    repeat (3) @(negedge clk);
    check("rst_value", {16'b0, value}, 0);
    check("rst_valid", {31'b0, valid}, 0);
    check("rst_err", {31'b0, err}, 0);
    check("rst_timeout", {31'b0, timeout}, 0);
    rst_n = 1'b1;
    idle(6);

    // basic frame and latency
    base_v = n_valid;
    frame(7'h4F, 7'h12, 7'h06, 7'h4C, 8);
    p = step_cyc;
    idle(8);
    check("basic_count", n_valid, base_v + 1);
    check("basic_value", {16'b0, value}, 32'h4321);
    check("basic_err", {31'b0, err}, 0);
    check("basic_latency", last_valid_cyc - p, 2 + S + 1);

    // position 1 shown too briefly
    base_v = n_valid;
    drive(4'b1110, 7'h4F, 8);
    drive(4'b1101, 7'h12, 3);
    drive(4'b1011, 7'h06, 8);
    drive(4'b0111, 7'h4C, 8);
    check("short_no_valid", n_valid, base_v);
    drive(4'b1101, 7'h12, 6);
    idle(8);
    check("short_count", n_valid, base_v + 1);
    check("short_value", {16'b0, value}, 32'h4321);

    // undecodable digit, then a clean frame
    frame(7'h01, 7'h01, 7'h7F, 7'h01, 8);
    idle(8);
    check("bad_value", {16'b0, value}, 0);
    check("bad_err", {31'b0, err}, 1);
    idle(5);
    check("bad_err_hold", {31'b0, err}, 1);
    frame(7'h30, 7'h38, 7'h00, 7'h04, 8);
    idle(8);
    check("clean_value", {16'b0, value}, 32'h98FE);
    check("clean_err", {31'b0, err}, 0);

    // two anodes low: long hold before the frame, shorter one mid-frame
    base_v = n_valid;
    drive(4'b1100, 7'h01, 20);
    drive(4'b1110, 7'h24, 4);
    drive(4'b1100, 7'h24, 10);
    drive(4'b1101, 7'h20, 4);
    drive(4'b1011, 7'h0F, 4);
    drive(4'b0111, 7'h08, 4);
    idle(8);
    check("multi_an_count", n_valid, base_v + 1);
    check("multi_an_value", {16'b0, value}, 32'hA765);

    // duplicate position restarts the frame
    base_v = n_valid;
    drive(4'b1110, 7'h00, 8);
    drive(4'b1101, 7'h31, 8);
    drive(4'b1110, 7'h60, 8);
    drive(4'b1101, 7'h42, 8);
    drive(4'b1011, 7'h30, 8);
    drive(4'b0111, 7'h38, 8);
    idle(8);
    check("restart_count", n_valid, base_v + 1);
    check("restart_value", {16'b0, value}, 32'hFEDB);

    // abandoned frame
    base_v = n_valid;
    base_t = n_tmo;
    drive(4'b1110, 7'h01, 8);
    drive(4'b1101, 7'h4F, 8);
    idle(30);
    check("tmo_count", n_tmo, base_t + 1);
    check("tmo_model", n_tmo, exp_tmo);
    check("tmo_no_valid", n_valid, base_v);
    check("tmo_value_kept", {16'b0, value}, 32'hFEDB);

    // reset mid-frame with a legal digit on the pins
    drive(4'b1110, 7'h12, 8);
    drive(4'b1101, 7'h06, 3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_value", {16'b0, value}, 0);
    check("midrst_valid", {31'b0, valid}, 0);
    check("midrst_err", {31'b0, err}, 0);
    check("midrst_timeout", {31'b0, timeout}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    an_L = 4'hF;
    seg_L = 7'h7F;
    m_reset();
    base_v = n_valid;
    base_t = n_tmo;
    idle(40);
    check("postrst_no_valid", n_valid, base_v);
    check("postrst_no_tmo", n_tmo, base_t);
    frame(7'h4F, 7'h12, 7'h06, 7'h4C, 6);
    idle(8);
    check("postrst_value", {16'b0, value}, 32'h4321);
    check("postrst_count", n_valid, base_v + 1);

    // randomized steps against the model
    for (int i = 0; i < 120; i++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        an = 4'($urandom_range(0, 15));
        while ($countones(~an) == 1) an = 4'($urandom_range(0, 15));
        seg = 7'($urandom_range(0, 127));
        n = $urandom_range(1, 8);
      end else begin
        p = $urandom_range(0, 3);
        an = ~(4'b0001 << p);
        if ($urandom_range(0, 7) == 0) seg = 7'($urandom_range(0, 127));
        else seg = seg_tab[$urandom_range(0, 15)];
        n = (kind == 1) ? $urandom_range(1, 3) : $urandom_range(4, 10);
      end
      drive(an, seg, n);
    end
    idle(40);
    check("rand_frames_left", exp_q.size(), 0);
    check("rand_tmo", n_tmo, exp_tmo);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
